spi_slave_receiver: RTL and testbench

Parameterisable SPI slave receive path, system-clock synchronous. Oversamples external ss/sclk/sdi pins, shifts in serial data on the mode-selected sclk edge, and presents the completed parallel word with a one-cycle valid strobe. It sits behind the board SPI pins, ahead of register or command decoding. Its stimulus companion is spi_stimulus (ss/sclk pattern generator); it is bench-only and not synthesised.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_input_sync.sv | 40 ++++
 rtl/spi_slave_receiver.sv | 139 +++++++++++++
 tb/tb_spi_slave_receiver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave receive path.
//  - spi_mode_t     : SPI mode number built from {CPOL, CPHA}
//  - CPOL_* / CPHA_*: named clock polarity / phase values
//  - spi_mode()     : packs CPOL/CPHA into a mode number
//  - sample_on_rise(): 1 when data is sampled on the rising edge of sclk
package spi_pkg;

   typedef enum logic [1:0] {
      SPI_MODE0 = 2'b00,
      SPI_MODE1 = 2'b01,
      SPI_MODE2 = 2'b10,
      SPI_MODE3 = 2'b11
   } spi_mode_t;

   localparam logic CPOL_IDLE_LOW  = 1'b0;
   localparam logic CPOL_IDLE_HIGH = 1'b1;
   localparam logic CPHA_LEADING   = 1'b0;
   localparam logic CPHA_TRAILING  = 1'b1;

   function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
      return spi_mode_t'({cpol, cpha});
   endfunction

   // Leading edge leaves the idle level, trailing edge returns to it.
   // Modes 0 and 3 therefore sample on a rising sclk, modes 1 and 2 on a falling one.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return ~(cpol ^ cpha);
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer plus one history flop for edge detection.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   din            : asynchronous input pin
//   level          : synchronized level
//   rise, fall     : single-cycle strobes on a synchronized edge
// All three flops reset to idle_level so no edge is seen on reset release
// while the pin sits at its idle level.
module spi_input_sync #(
   parameter logic idle_level = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic hist;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= idle_level;
         sync <= idle_level;
         hist <= idle_level;
      end else begin
         meta <= din;
         sync <= meta;
         hist <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~hist;
   assign fall  = ~sync & hist;

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI slave receive path, fully synchronous to clock.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   ss, sclk, sdi  : asynchronous SPI pins (slave select, serial clock, MOSI)
//   trigger        : external latch request (external-trigger mode only)
//   data [W-1:0]   : received word (W = bitcount+1)
//   valid          : one-cycle strobe marking a new word on data
// Handshake: valid has no back-pressure; each word is presented for exactly
// one clock with valid=1 and the consumer must take it in that cycle.
module spi_slave_receiver
   import spi_pkg::*;
#(
   parameter logic ss_polarity          = 1'b1,
   parameter logic sclk_polarity        = 1'b0,
   parameter logic sclk_phase           = 1'b1,
   parameter int   bitcount             = 7,
   parameter bit   msb_first            = 1'b1,
   parameter bit   use_gated_output     = 1'b1,
   parameter bit   use_external_trigger = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ss,
   input  logic              sclk,
   input  logic              sdi,
   input  logic              trigger,
   output logic [bitcount:0] data,
   output logic              valid
);

   localparam int   W           = bitcount + 1;
   localparam int   CW          = $clog2(W + 1);
   localparam logic sample_rise = sample_on_rise(sclk_polarity, sclk_phase);

   logic ss_lvl, ss_rise, ss_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic sdi_lvl, sdi_rise, sdi_fall;
   logic trig_lvl, trig_rise, trig_fall;

   spi_input_sync #(.idle_level(~ss_polarity)) u_sync_ss (
      .clock(clock), .reset_n(reset_n), .din(ss),
      .level(ss_lvl), .rise(ss_rise), .fall(ss_fall));
   spi_input_sync #(.idle_level(sclk_polarity)) u_sync_sclk (
      .clock(clock), .reset_n(reset_n), .din(sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
   spi_input_sync #(.idle_level(1'b0)) u_sync_sdi (
      .clock(clock), .reset_n(reset_n), .din(sdi),
      .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall));
   spi_input_sync #(.idle_level(1'b0)) u_sync_trig (
      .clock(clock), .reset_n(reset_n), .din(trigger),
      .level(trig_lvl), .rise(trig_rise), .fall(trig_fall));

   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, sdi_rise, sdi_fall, trig_lvl, trig_fall};

   logic ss_active, ss_start, ss_stop, sample_edge, take;

   assign ss_active   = (ss_lvl == ss_polarity);
   assign ss_start    = ss_polarity ? ss_rise : ss_fall;
   assign ss_stop     = ss_polarity ? ss_fall : ss_rise;
   assign sample_edge = sample_rise ? sclk_rise : sclk_fall;
   // A sample edge that coincides with ss going inactive still counts, so a
   // frame whose last edge and ss release land in one cycle keeps its word.
   assign take        = sample_edge & (ss_active | ss_stop);

   logic [W-1:0]  shift_q, shift_d, shift_base;
   logic [CW-1:0] cnt_q, cnt_d, cnt_base;
   logic          word_done, done_q;
   logic [W-1:0]  hold_q;
   logic          load;
   logic [W-1:0]  load_word;

   always_comb begin
      shift_base = ss_start ? '0 : shift_q;
      cnt_base   = ss_start ? '0 : cnt_q;
      shift_d    = shift_base;
      cnt_d      = cnt_base;
      word_done  = 1'b0;
      if (take) begin
         if (msb_first)
            shift_d = (shift_base << 1) | W'(sdi_lvl);
         else
            shift_d = (shift_base >> 1) | (W'(sdi_lvl) << bitcount);
         if (cnt_base == CW'(bitcount)) begin
            cnt_d     = '0;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_base + CW'(1);
         end
      end
      // Partial word on ss release is dropped; a completed one stays in
      // shift_q for one more cycle so it can be transferred.
      if (ss_stop && !word_done) begin
         shift_d = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         done_q  <= word_done;
         if (done_q)
            hold_q <= shift_q;
      end
   end

   // shift_q is untouched for at least two cycles after a completion
   // (sclk edges are at least two clocks apart), so it is read directly.
   always_comb begin
      if (use_external_trigger) begin
         load      = trig_rise;
         load_word = hold_q;
      end else begin
         load      = done_q;
         load_word = shift_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= load;
         if (load)
            data <= load_word;
         else if (use_gated_output)
            data <= '0;
      end
   end

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Four receivers (one per CPOL/CPHA mode, with varied ss polarity, bit order,
// gating and trigger mode) share one logical SPI stimulus. Each pin is derived
// from the logical select/clock level and the instance's polarities.
module tb_spi_slave_receiver;

   localparam int W  = 4;
   localparam int BC = W - 1;
   // Bit i belongs to receiver i.
   localparam logic [3:0] CPOL_V = 4'b1100;
   localparam logic [3:0] CPHA_V = 4'b1001;
   localparam logic [3:0] SSP_V  = 4'b0101;
   localparam logic [3:0] MSB_V  = 4'b0101;
   localparam logic [3:0] GATE_V = 4'b0101;
   localparam logic [3:0] EXT_V  = 4'b0100;

   // ---------------- clock / reset ----------------
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic sel  = 1'b0;  // logical slave select, 1 = active
   logic sck  = 1'b0;  // logical sclk, 1 = away from idle level
   logic sdi  = 1'b0;
   logic trig = 1'b0;

   logic [W-1:0] data_o [4];
   logic         valid_o[4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_receiver #(
         .ss_polarity(SSP_V[g]), .sclk_polarity(CPOL_V[g]), .sclk_phase(CPHA_V[g]),
         .bitcount(BC), .msb_first(MSB_V[g]), .use_gated_output(GATE_V[g]),
         .use_external_trigger(EXT_V[g])
      ) u_dut (
         .clock(clock),
         .reset_n(reset_n),
         .ss(sel ? SSP_V[g] : ~SSP_V[g]),
         .sclk(sck ^ CPOL_V[g]),
         .sdi(sdi),
         .trigger(EXT_V[g] ? trig : 1'b0),
         .data(data_o[g]),
         .valid(valid_o[g])
      );
   end

   // ---------------- scoreboard / model ----------------
   logic [W-1:0] exp_q[4][$];
   logic [W-1:0] last_word[4];
   logic [W-1:0] held;
   logic [W-1:0] grp;
   int           grp_n;
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // bits[j] is the j-th bit received on the wire.
   function automatic logic [W-1:0] word_of(input logic [W-1:0] bits, input logic msb);
      logic [W-1:0] w;
      for (int j = 0; j < W; j++)
         w[msb ? (W - 1 - j) : j] = bits[j];
      return w;
   endfunction

   task automatic model_bit(input logic b);
      grp[grp_n] = b;
      grp_n++;
      if (grp_n == W) begin
         for (int i = 0; i < 4; i++)
            if (!EXT_V[i]) exp_q[i].push_back(word_of(grp, MSB_V[i]));
         held  = word_of(grp, MSB_V[2]);
         grp_n = 0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         exp_q[i].delete();
         last_word[i] = '0;
      end
      held  = '0;
      grp_n = 0;
   endtask

   always @(negedge clock) begin
      logic [W-1:0] e;
      if (reset_n) begin
         for (int i = 0; i < 4; i++) begin
            if (valid_o[i]) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("u%0d unexpected valid, queue depth", i), 32'(exp_q[i].size()), 32'd1);
               end else begin
                  e = exp_q[i].pop_front();
                  check($sformatf("u%0d word", i), 32'(data_o[i]), 32'(e));
                  last_word[i] = e;
               end
            end else begin
               check($sformatf("u%0d idle data", i), 32'(data_o[i]),
                     GATE_V[i] ? 32'd0 : 32'(last_word[i]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic put_bit(input logic b, input bit tight_last);
      sdi = b;
      model_bit(b);
      wait_clk(3);
      sck = 1'b1;
      wait_clk(3);
      sck = 1'b0;
      if (tight_last) sel = 1'b0;
      wait_clk(3);
   endtask

   // pattern[j] is the j-th bit sent.
   task automatic frame(input int nbits, input bit tight, input logic [31:0] pattern);
      sel   = 1'b1;
      grp_n = 0;
      wait_clk(3);
      for (int j = 0; j < nbits; j++)
         put_bit(pattern[j], tight && (j == nbits - 1));
      sel   = 1'b0;
      grp_n = 0;
      wait_clk(6);
   endtask

   task automatic pulse_trigger();
      wait_clk(2);
      trig = 1'b1;
      exp_q[2].push_back(held);
      wait_clk(3);
      trig = 1'b0;
      wait_clk(6);
   endtask

   task automatic idle_sclk(input int n);
      for (int j = 0; j < n; j++) begin
         sdi = 1'($urandom_range(0, 1));
         wait_clk(3);
         sck = 1'b1;
         wait_clk(3);
         sck = 1'b0;
      end
      wait_clk(6);
   endtask

   task automatic reset_mid(input int k);
      sel   = 1'b1;
      grp_n = 0;
      wait_clk(3);
      for (int j = 0; j < k; j++)
         put_bit(1'($urandom_range(0, 1)), 1'b0);
      sck = 1'b1;
      #1;
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("u%0d data in reset", i), 32'(data_o[i]), 32'd0);
         check($sformatf("u%0d valid in reset", i), 32'(valid_o[i]), 32'd0);
      end
      model_reset();
      sel = 1'b0;
      sck = 1'b0;
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(3);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int r;
      model_reset();
      wait_clk(3);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("u%0d reset data", i), 32'(data_o[i]), 32'd0);
         check($sformatf("u%0d reset valid", i), 32'(valid_o[i]), 32'd0);
      end
      reset_n = 1'b1;
      wait_clk(3);

      frame(4, 1'b0, 32'hF);   // all ones
      frame(4, 1'b0, 32'h1);   // 1,0,0,0
      frame(4, 1'b0, 32'h0);   // all zeros
      frame(2, 1'b0, 32'h3);   // aborted after two bits
      frame(4, 1'b0, 32'hD);   // 1,0,1,1 after the abort
      pulse_trigger();
      frame(4, 1'b1, 32'h6);   // ss release together with the last edge
      frame(8, 1'b0, 32'hA5);  // two words in one frame
      idle_sclk(3);
      pulse_trigger();
      reset_mid(2);
      frame(4, 1'b0, 32'h5);
      pulse_trigger();

      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         if (r < 6)
            frame($urandom_range(1, 3 * W), 1'($urandom_range(0, 1)), $urandom());
         else if (r < 8)
            pulse_trigger();
         else if (r < 9)
            idle_sclk($urandom_range(1, 3));
         else
            reset_mid($urandom_range(0, BC));
      end

      wait_clk(10);
      for (int i = 0; i < 4; i++)
         check($sformatf("u%0d words left undelivered", i), 32'(exp_q[i].size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
